multicycle_ctrl: RTL and testbench

//  Multicycle MIPS control FSM. Sequences the shared datapath (one memory, one ALU,
//  IR, A/B/ALUOut regs) through fetch/decode/execute steps per instruction.

---
 rtl/mips_ctrl_pkg.sv | 56 +++++
 rtl/mc_out_dec.sv | 70 +++++++
 rtl/multicycle_ctrl.sv | 108 ++++++++++
 tb/tb_multicycle_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS control FSM.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_out_dec.sv
// Pure state -> control word decode. Memory-completion qualification is applied
// by the top level; here those bits are raised for the whole state.
module mc_out_dec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = ALUSRCB_FOUR;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
      end
      S_DECODE: ctrl.alusrcb = ALUSRCB_IMM_SH;
      S_MEMADR, S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.memtoreg   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req    = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.memwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_B;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.regdst     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl.alusrca    = 1'b1;
        ctrl.alusrcb    = ALUSRCB_B;
        ctrl.aluop      = ALUOP_SUB;
        ctrl.branch     = 1'b1;
        ctrl.pcsrc      = PCSRC_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcwrite    = 1'b1;
        ctrl.pcsrc      = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, sequencing, memory handshake
// and timeout supervision around the mc_out_dec control-word decoder.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       instr_done,
  output logic       bus_err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t          state;
  ctrl_t           raw;
  logic [TO_W-1:0] to_cnt;
  logic            waiting;
  logic            mem_done;
  logic            timeout_hit;
  logic            decode_nop;

  mc_out_dec u_dec (
    .state (state),
    .ctrl  (raw)
  );

  assign waiting     = raw.mem_req & ~mem_ready;
  assign mem_done    = ~raw.mem_req | mem_ready;
  assign timeout_hit = (MEM_TIMEOUT != 0) && waiting && (to_cnt == TO_LAST);
  assign decode_nop  = (state == S_DECODE) &&
                       !(op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});

  // A waiting request never changes state except through a timeout, so clearing
  // on !waiting also covers every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      to_cnt  <= '0;
      bus_err <= 1'b0;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXEC;
            OP_BEQ:       state <= S_BEQ;
            OP_ADDI:      state <= S_ADDIEX;
            OP_J:         state <= S_JUMP;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          if (op == OP_LW)      state <= S_MEMRD;
          else if (op == OP_SW) state <= S_MEMWR;
          else                  state <= S_FETCH;
        end
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_EXEC:   state <= S_ALUWB;
        S_ADDIEX: state <= S_ADDIWB;
        default:  state <= S_FETCH;
      endcase

      if (timeout_hit) begin
        state   <= S_FETCH;
        bus_err <= 1'b1;
      end

      if (timeout_hit || !waiting) to_cnt <= '0;
      else                         to_cnt <= to_cnt + 1'b1;
    end
  end

  assign mem_req    = raw.mem_req;
  assign iord       = raw.iord;
  assign memwrite   = raw.memwrite & ~timeout_hit;
  assign irwrite    = raw.irwrite & mem_ready;
  assign pcwrite    = raw.pcwrite & mem_done;
  assign branch     = raw.branch;
  assign pcsrc      = raw.pcsrc;
  assign alusrca    = raw.alusrca;
  assign alusrcb    = raw.alusrcb;
  assign aluop      = raw.aluop;
  assign regwrite   = raw.regwrite;
  assign regdst     = raw.regdst;
  assign memtoreg   = raw.memtoreg;
  assign instr_done = (raw.instr_done & mem_done) | decode_nop;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level reference model
// driven by a vector table, randomized instructions and handshake corner cases.
module tb_multicycle_ctrl;

  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010;

  typedef enum int {K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_J, K_NOP} kind_t;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       instr_done;
    logic       bus_err;
  } out_t;

  typedef struct {
    logic [5:0] op;
    int         fw;
    int         mw;
    int         done_at;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_ready;
  logic [5:0] op;
  logic       mem_req, iord, memwrite, irwrite, pcwrite, branch, alusrca;
  logic       regwrite, regdst, memtoreg, instr_done, bus_err;
  logic [1:0] pcsrc, alusrcb, aluop;
  out_t       actual;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc;
  int   done_at;
  logic exp_bus_err;

  multicycle_ctrl #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .branch     (branch),
    .pcsrc      (pcsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .instr_done (instr_done),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  assign actual = {mem_req, iord, memwrite, irwrite, pcwrite, branch, pcsrc, alusrca,
                   alusrcb, aluop, regwrite, regdst, memtoreg, instr_done, bus_err};

  function automatic kind_t kind_of(input logic [5:0] o);
    case (o)
      T_R:     return K_R;
      T_LW:    return K_LW;
      T_SW:    return K_SW;
      T_BEQ:   return K_BEQ;
      T_ADDI:  return K_ADDI;
      T_J:     return K_J;
      default: return K_NOP;
    endcase
  endfunction

  // Zero-wait cycle counts plus every wait cycle spent in fetch and data access.
  function automatic int exp_cycles(input logic [5:0] o, input int fw, input int mw);
    case (kind_of(o))
      K_R, K_ADDI: return 4 + fw;
      K_LW:        return 5 + fw + mw;
      K_SW:        return 4 + fw + mw;
      K_BEQ, K_J:  return 3 + fw;
      default:     return 2 + fw;
    endcase
  endfunction

  function automatic out_t base();
    out_t e = '0;
    e.bus_err = exp_bus_err;
    return e;
  endfunction

  function automatic out_t e_fetch(input logic rdy);
    out_t e = base();
    e.mem_req = 1'b1;
    e.alusrcb = 2'b01;
    e.irwrite = rdy;
    e.pcwrite = rdy;
    return e;
  endfunction

  task automatic check_output(input string name, input out_t exp);
    n_cmp++;
    if (actual !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, actual, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic [5:0] o, input out_t exp, input string name);
    @(negedge clk);
    mem_ready = rdy;
    op = o;
    #1;
    cyc++;
    check_output(name, exp);
    if (instr_done === 1'b1 && done_at == 0) done_at = cyc;
  endtask

  task automatic apply_stimulus(input vec_t v);
    out_t  e;
    kind_t k = kind_of(v.op);
    cyc = 0;
    done_at = 0;
    for (int i = 0; i < v.fw; i++) begin
      step(1'b0, 6'($urandom), e_fetch(1'b0), "fetch_wait");
      if ((i + 1) % 16 == 0) exp_bus_err = 1'b1;
    end
    step(1'b1, 6'($urandom), e_fetch(1'b1), "fetch");
    e = base();
    e.alusrcb = 2'b11;
    e.instr_done = (k == K_NOP);
    step(1'($urandom), v.op, e, "decode");
    case (k)
      K_R: begin
        e = base(); e.alusrca = 1'b1; e.aluop = 2'b10;
        step(1'($urandom), v.op, e, "exec");
        e = base(); e.regwrite = 1'b1; e.regdst = 1'b1; e.instr_done = 1'b1;
        step(1'($urandom), v.op, e, "aluwb");
      end
      K_LW, K_SW: begin
        e = base(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        step(1'($urandom), v.op, e, "memadr");
        for (int i = 0; i < v.mw && i < 16; i++) begin
          e = base(); e.mem_req = 1'b1; e.iord = 1'b1;
          e.memwrite = (k == K_SW) && (i != 15);
          step(1'b0, v.op, e, "mem_wait");
        end
        if (v.mw >= 16) begin
          exp_bus_err = 1'b1;
        end else begin
          e = base(); e.mem_req = 1'b1; e.iord = 1'b1;
          e.memwrite = (k == K_SW);
          e.instr_done = (k == K_SW);
          step(1'b1, v.op, e, "mem_access");
          if (k == K_LW) begin
            e = base(); e.regwrite = 1'b1; e.memtoreg = 1'b1; e.instr_done = 1'b1;
            step(1'($urandom), v.op, e, "memwb");
          end
        end
      end
      K_BEQ: begin
        e = base(); e.alusrca = 1'b1; e.aluop = 2'b01; e.branch = 1'b1;
        e.pcsrc = 2'b01; e.instr_done = 1'b1;
        step(1'($urandom), v.op, e, "beq");
      end
      K_ADDI: begin
        e = base(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        step(1'($urandom), v.op, e, "addiex");
        e = base(); e.regwrite = 1'b1; e.instr_done = 1'b1;
        step(1'($urandom), v.op, e, "addiwb");
      end
      K_J: begin
        e = base(); e.pcwrite = 1'b1; e.pcsrc = 2'b10; e.instr_done = 1'b1;
        step(1'($urandom), v.op, e, "jump");
      end
      default: ;
    endcase
    n_cmp++;
    if (done_at != v.done_at) begin
      n_bad++;
      $display("[TB] FAIL done_cycle op=%b: got %0d expected %0d", v.op, done_at, v.done_at);
    end
  endtask

  vec_t  table_v[10];
  vec_t  rv;
  out_t  e;
  logic [5:0] pick[7];

  initial begin
    table_v[0] = '{T_R,    0, 0, 4};
    table_v[1] = '{T_LW,   0, 3, 8};
    table_v[2] = '{T_SW,   0, 2, 6};
    table_v[3] = '{T_BEQ,  0, 0, 3};
    table_v[4] = '{T_J,    0, 0, 3};
    table_v[5] = '{6'h3f,  0, 0, 2};
    table_v[6] = '{T_ADDI, 1, 0, 5};
    table_v[7] = '{T_SW,   2, 0, 6};
    table_v[8] = '{T_LW,   0, 0, 5};
    table_v[9] = '{6'h01,  3, 0, 5};

    rst_n = 1'b0;
    mem_ready = 1'b0;
    op = 6'd0;
    exp_bus_err = 1'b0;
    cyc = 0;
    repeat (2) @(negedge clk);
    #1;
    check_output("reset", e_fetch(1'b0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (table_v[i]) apply_stimulus(table_v[i]);

    pick[0] = T_R; pick[1] = T_LW; pick[2] = T_SW; pick[3] = T_BEQ;
    pick[4] = T_ADDI; pick[5] = T_J;
    for (int n = 0; n < 40; n++) begin
      pick[6] = 6'($urandom);
      rv.op = pick[$urandom_range(0, 6)];
      rv.fw = $urandom_range(0, 3);
      rv.mw = $urandom_range(0, 4);
      rv.done_at = exp_cycles(rv.op, rv.fw, rv.mw);
      apply_stimulus(rv);
    end

    // Reset pulse while a store is still waiting for memory.
    cyc = 0;
    step(1'b1, 6'd0, e_fetch(1'b1), "rst_fetch");
    e = base(); e.alusrcb = 2'b11;
    step(1'b0, T_SW, e, "rst_decode");
    e = base(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
    step(1'b0, T_SW, e, "rst_memadr");
    e = base(); e.mem_req = 1'b1; e.iord = 1'b1; e.memwrite = 1'b1;
    step(1'b0, T_SW, e, "rst_memwr");
    rst_n = 1'b0;
    #1;
    check_output("async_reset", e_fetch(1'b0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    rv = '{T_R, 0, 0, 4};
    apply_stimulus(rv);

    // Memory timeouts: fetch restarts in place, data access aborts, error sticks.
    rv = '{T_R, 16, 0, 20};
    apply_stimulus(rv);
    rv = '{T_LW, 0, 16, 0};
    apply_stimulus(rv);
    rv = '{T_J, 1, 0, 4};
    apply_stimulus(rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
